// File: rtl/digit_counter_mux_pkg.sv
// Shared digit limits, segment layout and glyph constants.
// Define DECIMAL_MODE_EN for BCD digits (0-9); hex digits otherwise.
package digit_counter_mux_pkg;

  localparam int SEG_W  = 7;
  localparam int SEG_DP = 7;

  // glyph bit order {g,f,e,d,c,b,a}, 1 = segment lit
  localparam logic [SEG_W-1:0] G_0 = 7'h3F;
  localparam logic [SEG_W-1:0] G_1 = 7'h06;
  localparam logic [SEG_W-1:0] G_2 = 7'h5B;
  localparam logic [SEG_W-1:0] G_3 = 7'h4F;
  localparam logic [SEG_W-1:0] G_4 = 7'h66;
  localparam logic [SEG_W-1:0] G_5 = 7'h6D;
  localparam logic [SEG_W-1:0] G_6 = 7'h7D;
  localparam logic [SEG_W-1:0] G_7 = 7'h07;
  localparam logic [SEG_W-1:0] G_8 = 7'h7F;
  localparam logic [SEG_W-1:0] G_9 = 7'h6F;
  localparam logic [SEG_W-1:0] G_A = 7'h77;
  localparam logic [SEG_W-1:0] G_B = 7'h7C;
  localparam logic [SEG_W-1:0] G_C = 7'h39;
  localparam logic [SEG_W-1:0] G_D = 7'h5E;
  localparam logic [SEG_W-1:0] G_E = 7'h79;
  localparam logic [SEG_W-1:0] G_F = 7'h71;

  localparam logic [7:0] BLANK = 8'h00;

  localparam logic [3:0] HEX_MAX = 4'hF;
  localparam logic [3:0] DEC_MAX = 4'h9;

`ifdef DECIMAL_MODE_EN
  localparam bit DECIMAL = 1'b1;
`else
  localparam bit DECIMAL = 1'b0;
`endif

  localparam logic [3:0] DIGIT_MAX =
    DECIMAL ? DEC_MAX : HEX_MAX;

endpackage

// File: rtl/digit_counter_mux_seg7_decode.sv
// 4-bit digit to 7-segment glyph, active-high.
// Output polarity is applied by the caller.
module seg7_decode
  import digit_counter_mux_pkg::*;
(
  input  logic [3:0]       i_digit,
  output logic [SEG_W-1:0] o_glyph
);

  always_comb begin
    o_glyph = G_0;
    case (i_digit)
      4'h0: o_glyph = G_0;
      4'h1: o_glyph = G_1;
      4'h2: o_glyph = G_2;
      4'h3: o_glyph = G_3;
      4'h4: o_glyph = G_4;
      4'h5: o_glyph = G_5;
      4'h6: o_glyph = G_6;
      4'h7: o_glyph = G_7;
      4'h8: o_glyph = G_8;
      4'h9: o_glyph = G_9;
      4'hA: o_glyph = G_A;
      4'hB: o_glyph = G_B;
      4'hC: o_glyph = G_C;
      4'hD: o_glyph = G_D;
      4'hE: o_glyph = G_E;
      4'hF: o_glyph = G_F;
      default: o_glyph = G_0;
    endcase
  end

endmodule

// File: rtl/digit_counter_mux.sv
// Prescaled multi-digit up/down counter with muxed 7-seg display.
// DECIMAL_MODE_EN selects BCD digits instead of hex.
module digit_counter_mux
  import digit_counter_mux_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int PRESCALE_BITS  = 24,
  parameter int REFRESH_BITS   = 16,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  step,
  output logic                  wrap,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg
);

  localparam int IDXW =
    (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam bit LOW = (SEG_ACTIVE_LOW != 0);

  logic [PRESCALE_BITS-1:0] r_presc;
  logic [4*DIGITS-1:0]      r_count;
  logic                     r_step;
  logic                     r_wrap;
  logic [REFRESH_BITS-1:0]  r_refresh;
  logic [IDXW-1:0]          r_idx;
  logic [DIGITS-1:0]        r_an;
  logic [7:0]               r_seg;

  logic                     w_tick;
  logic [4*DIGITS-1:0]      w_count_nxt;
  logic [DIGITS:0]          w_carry;
  logic [3:0]               w_digit;
  logic [SEG_W-1:0]         w_glyph;
  logic [7:0]               w_seg_on;
  logic [DIGITS-1:0]        w_an_on;

  assign w_tick     = en & (&r_presc);
  assign w_carry[0] = 1'b1;

  // carry/borrow chain; digits above max come from loads only
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] w_d;
    logic [3:0] w_n;
    logic       w_c;
    logic       w_over;

    assign w_d = r_count[4*gi +: 4];
`ifdef DECIMAL_MODE_EN
    assign w_over = (w_d > DIGIT_MAX);
`else
    assign w_over = 1'b0;
`endif

    always_comb begin
      w_n = w_d;
      w_c = 1'b0;
      if (w_carry[gi]) begin
        if (up_down) begin
          if (w_over || w_d == DIGIT_MAX) begin
            w_n = 4'd0;
            w_c = 1'b1;
          end else begin
            w_n = w_d + 4'd1;
          end
        end else begin
          if (w_d == 4'd0) begin
            w_n = DIGIT_MAX;
            w_c = 1'b1;
          end else if (w_over) begin
            w_n = DIGIT_MAX - 4'd1;
          end else begin
            w_n = w_d - 4'd1;
          end
        end
      end
    end

    assign w_count_nxt[4*gi +: 4] = w_n;
    assign w_carry[gi+1]          = w_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_count <= '0;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_wrap <= 1'b0;
      if (load) begin
        r_count <= load_value;
        r_presc <= '0;
      end else if (en) begin
        r_presc <= r_presc + 1'b1;
        if (w_tick) begin
          r_count <= w_count_nxt;
          r_step  <= 1'b1;
          r_wrap  <= w_carry[DIGITS];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_refresh <= '0;
      r_idx     <= '0;
    end else begin
      r_refresh <= r_refresh + 1'b1;
      if (&r_refresh) begin
        if (r_idx == IDXW'(DIGITS-1))
          r_idx <= '0;
        else
          r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign w_digit = r_count[4*r_idx +: 4];

  seg7_decode u_dec (
    .i_digit (w_digit),
    .o_glyph (w_glyph)
  );

  always_comb begin
    w_seg_on         = {1'b0, w_glyph};
    w_seg_on[SEG_DP] = (r_idx == '0) & ~up_down;
    w_an_on          = '0;
    w_an_on[r_idx]   = 1'b1;
  end

  // an and seg share one register stage so they never disagree
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= LOW ? '1 : '0;
      r_seg <= LOW ? ~BLANK : BLANK;
    end else begin
      r_an  <= LOW ? ~w_an_on : w_an_on;
      r_seg <= LOW ? ~w_seg_on : w_seg_on;
    end
  end

  assign count = r_count;
  assign step  = r_step;
  assign wrap  = r_wrap;
  assign an    = r_an;
  assign seg   = r_seg;

endmodule

// File: tb/tb_digit_counter_mux.sv
// Directed bench for digit_counter_mux (4 digits, fast prescale/refresh).
// Build with DECIMAL_MODE_EN defined to exercise the BCD vectors.
module tb_digit_counter_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        up_down;
  logic        load;
  logic [15:0] load_value;
  logic [15:0] count;
  logic        step;
  logic        wrap;
  logic [3:0]  an;
  logic [7:0]  seg;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  digit_counter_mux #(
    .DIGITS         (4),
    .PRESCALE_BITS  (2),
    .REFRESH_BITS   (1),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .step       (step),
    .wrap       (wrap),
    .an         (an),
    .seg        (seg)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(
    input logic [3:0] d
  );
    logic [6:0] g;
    case (d)
      4'h0: g = 7'b0111111;
      4'h1: g = 7'b0000110;
      4'h2: g = 7'b1011011;
      4'h3: g = 7'b1001111;
      4'h4: g = 7'b1100110;
      4'h5: g = 7'b1101101;
      4'h6: g = 7'b1111101;
      4'h7: g = 7'b0000111;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1101111;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b1111100;
      4'hC: g = 7'b0111001;
      4'hD: g = 7'b1011110;
      4'hE: g = 7'b1111001;
      default: g = 7'b1110001;
    endcase
    return g;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    load_value = v;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  task automatic wait_an(
    input string      tag,
    input logic [3:0] want
  );
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 16 && !hit; i++) begin
      @(negedge clk);
      if (an == want) hit = 1'b1;
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    int         steps;
    int         bad_cnt;
    int         bad_stp;
    int         bad_an;
    int         bad_seg;
    int         chg;
    int         k;
    logic [3:0] prev;
    logic [3:0] d;
    logic [7:0] es;

    reset      = 1'b1;
    en         = 1'b0;
    up_down    = 1'b1;
    load       = 1'b0;
    load_value = '0;
    #3;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_an",    32'(an),    32'hF);
    chk("rst_seg",   32'(seg),   32'hFF);
    chk("rst_step",  32'(step),  32'h0);
    chk("rst_wrap",  32'(wrap),  32'h0);
    clks(2);

    // 1: first step after four enabled clocks
    reset = 1'b0;
    en    = 1'b1;
    steps = 0;
    repeat (4) begin
      @(negedge clk);
      steps += int'(step);
    end
    chk("t1_count", 32'(count), 32'h0001);
    chk("t1_steps", 32'(steps), 32'd1);
    chk("t1_step",  32'(step),  32'd1);
    chk("t1_wrap",  32'(wrap),  32'd0);

`ifndef DECIMAL_MODE_EN
    // 2: hex wrap max -> 0
    do_load(16'hFFFE);
    chk("t2_ld",    32'(count), 32'hFFFE);
    chk("t2_ldstp", 32'(step),  32'd0);
    clks(4);
    chk("t2_c1",    32'(count), 32'hFFFF);
    chk("t2_w1",    32'(wrap),  32'd0);
    clks(4);
    chk("t2_c2",    32'(count), 32'h0000);
    chk("t2_s2",    32'(step),  32'd1);
    chk("t2_w2",    32'(wrap),  32'd1);

    // 3: hex ripple carry and borrow wrap
    do_load(16'h0FFF);
    clks(4);
    chk("t3_up",    32'(count), 32'h1000);
    chk("t3_upw",   32'(wrap),  32'd0);
    up_down = 1'b0;
    do_load(16'h0000);
    clks(4);
    chk("t3_dn",    32'(count), 32'hFFFF);
    chk("t3_dnw",   32'(wrap),  32'd1);
`else
    // 3: BCD carry/borrow and out-of-range digits
    do_load(16'h0999);
    clks(4);
    chk("t3_up",    32'(count), 32'h1000);
    chk("t3_upw",   32'(wrap),  32'd0);
    up_down = 1'b0;
    do_load(16'h0000);
    clks(4);
    chk("t3_dn",    32'(count), 32'h9999);
    chk("t3_dnw",   32'(wrap),  32'd1);
    up_down = 1'b1;
    do_load(16'h000C);
    clks(4);
    chk("t3_ovup",  32'(count), 32'h0010);
    up_down = 1'b0;
    do_load(16'h000C);
    clks(4);
    chk("t3_ovdn",  32'(count), 32'h0008);
    chk("t3_ovdw",  32'(wrap),  32'd0);
`endif

    // dp lit on digit 0 only while counting down
    up_down = 1'b0;
    wait_an("dp_wait0", 4'b1110);
    chk("dp_down", 32'(seg[7]), 32'd0);
    up_down = 1'b1;
    wait_an("dp_wait1", 4'b1110);
    chk("dp_up",   32'(seg[7]), 32'd1);

    // 4: freeze with prescaler parked at 2
    do_load(16'h00A0);
    clks(2);
    en      = 1'b0;
    bad_cnt = 0;
    bad_stp = 0;
    bad_an  = 0;
    bad_seg = 0;
    chg     = 0;
    prev    = an;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (count != 16'h00A0) bad_cnt++;
      if (step) bad_stp++;
      if (an != prev) begin
        chg++;
        if (an != {prev[2:0], prev[3]}) bad_an++;
      end
      prev = an;
      k = -1;
      for (int j = 0; j < 4; j++)
        if (an == ~(4'b0001 << j)) k = j;
      if (k < 0) begin
        bad_an++;
      end else begin
        d  = count[4*k +: 4];
        es = ~{1'b0, glyph(d)};
        if (seg != es) bad_seg++;
      end
    end
    chk("t4_count", 32'(bad_cnt), 32'd0);
    chk("t4_step",  32'(bad_stp), 32'd0);
    chk("t4_anseq", 32'(bad_an),  32'd0);
    chk("t4_anchg", 32'(chg),     32'd10);
    chk("t4_seg",   32'(bad_seg), 32'd0);
    en = 1'b1;
    clks(1);
    chk("t4_hold",  32'(count), 32'h00A0);
    clks(1);
    chk("t4_resume", 32'(count), 32'h00A1);
    chk("t4_rstep",  32'(step),  32'd1);

    // 5: load beats a step on the terminal prescaler value
    do_load(16'h0000);
    clks(3);
    do_load(16'h1234);
    chk("t5_ld",    32'(count), 32'h1234);
    chk("t5_stp",   32'(step),  32'd0);
    chk("t5_wrp",   32'(wrap),  32'd0);
    clks(3);
    chk("t5_c3",    32'(count), 32'h1234);
    chk("t5_s3",    32'(step),  32'd0);
    clks(1);
    chk("t5_c4",    32'(count), 32'h1235);
    chk("t5_s4",    32'(step),  32'd1);
    en = 1'b0;
    do_load(16'h5678);
    chk("t5_ld_en0", 32'(count), 32'h5678);

    // 6: asynchronous reset mid-count with digit 2 lit
    en = 1'b1;
    wait_an("t6_wait", 4'b1011);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_an",    32'(an),    32'hF);
    chk("t6_seg",   32'(seg),   32'hFF);
    chk("t6_count", 32'(count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    clks(1);
    chk("t6_an0",   32'(an),    32'b1110);
    clks(3);
    chk("t6_rec",   32'(count), 32'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
